// File: rtl/bp_types.sv
// Shared types and helpers for the branch predictor: BTB entry layout,
// index/tag extraction and the reset value of the direction counters.
package bp_types;

    // Widest tag (IDX_BITS >= 2) and widest counter the predictor supports.
    localparam int unsigned TAG_MAX = 28;
    localparam int unsigned CTR_MAX = 4;

    // One BTB entry. Unused upper tag/ctr bits are held at zero.
    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [31:0]        target;
        logic               is_jump;
        logic [CTR_MAX-1:0] ctr;
    } btb_entry_t;

    // Weakly not-taken counter value: 2^(bits-1) - 1.
    function automatic int unsigned bp_ctr_init(input int unsigned bits);
        return (32'd1 << (bits - 32'd1)) - 32'd1;
    endfunction

    // Constant reset value for the default 2-bit counters.
    localparam int unsigned CTR_INIT = bp_ctr_init(2);

    // Table index: word-address bits of the PC, optionally folded with history.
    function automatic logic [31:0] bp_index(input logic [31:0] pc, input logic [31:0] ghr,
                                             input int unsigned idx_bits);
        return ((pc >> 2) ^ ghr) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    // Tag: every PC bit above the index field.
    function automatic logic [TAG_MAX-1:0] bp_tag(input logic [31:0] pc,
                                                  input int unsigned idx_bits);
        return TAG_MAX'(pc >> (idx_bits + 32'd2));
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module bp_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled events, holding at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, optional
// gshare indexing, mispredict/redirect resolution and lookup statistics.
module branch_predictor
    import bp_types::*;
#(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned USE_GSHARE  = 0,
    parameter int unsigned GHR_BITS    = 4,
    parameter int unsigned STAT_WIDTH  = 32,
    localparam int unsigned IDX_BITS   = $clog2(NUM_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           if_pc,
    input  logic                  if_stall,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    output logic                  pred_hit,
    output logic [IDX_BITS-1:0]   pred_index,
    input  logic                  upd_valid,
    input  logic                  upd_stall,
    input  logic [31:0]           upd_pc,
    input  logic [IDX_BITS-1:0]   upd_index,
    input  logic                  upd_is_branch,
    input  logic                  upd_is_jump,
    input  logic                  upd_taken,
    input  logic [31:0]           upd_target,
    input  logic                  upd_pred_taken,
    input  logic [31:0]           upd_pred_target,
    output logic                  mispredict,
    output logic [31:0]           correct_pc,
    output logic [STAT_WIDTH-1:0] stat_lookups,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam logic [CTR_MAX-1:0] CTR_RST   = CTR_MAX'(bp_ctr_init(CTR_BITS));
    localparam logic [CTR_MAX-1:0] CTR_ALLOC = CTR_RST + CTR_MAX'(1);
    localparam logic [CTR_MAX-1:0] CTR_ONES  = CTR_MAX'((32'd1 << CTR_BITS) - 32'd1);

    btb_entry_t          tbl_q [NUM_ENTRIES];
    logic [GHR_BITS-1:0] ghr_q;
    logic [31:0]         ghr_ext;
    btb_entry_t          look_e;
    btb_entry_t          upd_e;
    btb_entry_t          wr_e;
    logic                upd_hit;
    logic                wr_en;
    logic                ghr_shift;
    logic                actual;

    // Lookup path: index, tag compare and next-fetch PC from the registered table.
    always_comb begin
        ghr_ext     = (USE_GSHARE != 0) ? 32'(ghr_q) : 32'd0;
        pred_index  = IDX_BITS'(bp_index(if_pc, ghr_ext, IDX_BITS));
        look_e      = tbl_q[pred_index];
        pred_hit    = look_e.valid && (look_e.tag == bp_tag(if_pc, IDX_BITS));
        // Counter MSB set is equivalent to ctr above the weakly-not-taken value.
        pred_taken  = pred_hit && (look_e.is_jump || (look_e.ctr > CTR_RST));
        pred_target = pred_taken ? look_e.target : if_pc + 32'd4;
    end

    // Resolution path: compare the carried prediction against the real outcome.
    always_comb begin
        actual     = upd_is_jump || (upd_is_branch && upd_taken);
        mispredict = upd_valid && ((actual != upd_pred_taken) ||
                                   (actual && (upd_pred_target != upd_target)));
        correct_pc = actual ? upd_target : upd_pc + 32'd4;
    end

    // Training decision for the entry named by upd_index.
    always_comb begin
        upd_e     = tbl_q[upd_index];
        upd_hit   = upd_e.valid && (upd_e.tag == bp_tag(upd_pc, IDX_BITS));
        wr_en     = 1'b0;
        wr_e      = upd_e;
        ghr_shift = 1'b0;
        if (upd_valid && !upd_stall) begin
            if (upd_is_jump) begin
                wr_en = 1'b1;
                wr_e  = '{valid: 1'b1, tag: bp_tag(upd_pc, IDX_BITS), target: upd_target,
                          is_jump: 1'b1, ctr: CTR_ONES};
            end else if (upd_is_branch) begin
                ghr_shift = 1'b1;
                if (upd_hit) begin
                    wr_en = 1'b1;
                    if (upd_taken) begin
                        wr_e.target = upd_target;
                        if (upd_e.ctr != CTR_ONES) wr_e.ctr = upd_e.ctr + CTR_MAX'(1);
                    end else if (upd_e.ctr != '0) begin
                        wr_e.ctr = upd_e.ctr - CTR_MAX'(1);
                    end
                end else if (upd_taken) begin
                    wr_en = 1'b1;
                    wr_e  = '{valid: 1'b1, tag: bp_tag(upd_pc, IDX_BITS), target: upd_target,
                              is_jump: 1'b0, ctr: CTR_ALLOC};
                end
            end else if (upd_hit && upd_pred_taken) begin
                // Non-control instruction aliased onto a taken entry: drop it.
                wr_en       = 1'b1;
                wr_e.valid  = 1'b0;
            end
        end
    end

    // Table and history state; reset wins over a concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                tbl_q[i].valid <= 1'b0;
                tbl_q[i].ctr   <= CTR_RST;
            end
            ghr_q <= '0;
        end else begin
            if (wr_en) tbl_q[upd_index] <= wr_e;
            if (ghr_shift && (USE_GSHARE != 0)) begin
                ghr_q <= (ghr_q << 1) | GHR_BITS'(upd_taken);
            end
        end
    end

    bp_sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_stat_lookups (
        .clk   (clk),
        .rst   (rst),
        .en    (!if_stall),
        .count (stat_lookups)
    );

    bp_sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_stat_mispredicts (
        .clk   (clk),
        .rst   (rst),
        .en    (mispredict && !upd_stall),
        .count (stat_mispredicts)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a gshare instance share one
// stimulus stream and are checked each cycle against a table-level model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_stall;
    logic        upd_valid, upd_stall, upd_is_branch, upd_is_jump, upd_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        upd_pred_taken;
    logic [3:0]  a_upd_index, g_upd_index;

    logic        a_pred_taken, a_pred_hit, a_mispredict;
    logic [31:0] a_pred_target, a_correct_pc, a_stat_lookups, a_stat_mispredicts;
    logic [3:0]  a_pred_index;
    logic        g_pred_taken, g_pred_hit, g_mispredict;
    logic [31:0] g_pred_target, g_correct_pc, g_stat_lookups, g_stat_mispredicts;
    logic [3:0]  g_pred_index;

    always #5 clk = ~clk;

    branch_predictor #(.NUM_ENTRIES(16), .CTR_BITS(2), .USE_GSHARE(0), .GHR_BITS(4),
                       .STAT_WIDTH(32)) u_dut_a (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_stall(if_stall),
        .pred_taken(a_pred_taken), .pred_target(a_pred_target), .pred_hit(a_pred_hit),
        .pred_index(a_pred_index), .upd_valid(upd_valid), .upd_stall(upd_stall),
        .upd_pc(upd_pc), .upd_index(a_upd_index), .upd_is_branch(upd_is_branch),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(a_mispredict), .correct_pc(a_correct_pc),
        .stat_lookups(a_stat_lookups), .stat_mispredicts(a_stat_mispredicts)
    );

    branch_predictor #(.NUM_ENTRIES(16), .CTR_BITS(2), .USE_GSHARE(1), .GHR_BITS(4),
                       .STAT_WIDTH(32)) u_dut_g (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_stall(if_stall),
        .pred_taken(g_pred_taken), .pred_target(g_pred_target), .pred_hit(g_pred_hit),
        .pred_index(g_pred_index), .upd_valid(upd_valid), .upd_stall(upd_stall),
        .upd_pc(upd_pc), .upd_index(g_upd_index), .upd_is_branch(upd_is_branch),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(g_mispredict), .correct_pc(g_correct_pc),
        .stat_lookups(g_stat_lookups), .stat_mispredicts(g_stat_mispredicts)
    );

    // Reference model: [0] bimodal, [1] gshare.
    bit          m_valid [2][16];
    logic [31:0] m_tag   [2][16];
    logic [31:0] m_tgt   [2][16];
    bit          m_jmp   [2][16];
    int          m_ctr   [2][16];
    int          m_ghr   [2];
    int unsigned m_look  [2];
    int unsigned m_mis   [2];

    int compared = 0;
    int mismatched = 0;

    // Values observed at the most recent sample point.
    logic        o_hit, o_tk, o_mis, o_ghit;
    logic [31:0] o_tgt, o_cpc, o_look, o_smis;
    logic [3:0]  o_gidx;

    function automatic int idx_of(input int g, input logic [31:0] pc);
        int h;
        h = (g == 1) ? m_ghr[1] : 0;
        return (int'(pc >> 2) ^ h) & 15;
    endfunction

    task automatic predict(input int g, input logic [31:0] pc, output bit hit, output bit tk,
                           output logic [31:0] tgt, output int idx);
        idx = idx_of(g, pc);
        hit = m_valid[g][idx] && (m_tag[g][idx] == (pc >> 6));
        tk  = hit && (m_jmp[g][idx] || (m_ctr[g][idx] >= 2));
        tgt = tk ? m_tgt[g][idx] : pc + 32'd4;
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[g][i] = 1'b0;
                m_ctr[g][i]   = 1;
            end
            m_ghr[g] = 0;
            m_look[g] = 0;
            m_mis[g] = 0;
        end
    endtask

    task automatic model_train(input int g, input int ui);
        bit hit;
        if (!(upd_valid && !upd_stall)) return;
        hit = m_valid[g][ui] && (m_tag[g][ui] == (upd_pc >> 6));
        if (upd_is_jump) begin
            m_valid[g][ui] = 1'b1; m_tag[g][ui] = upd_pc >> 6; m_tgt[g][ui] = upd_target;
            m_jmp[g][ui] = 1'b1; m_ctr[g][ui] = 3;
        end else if (upd_is_branch) begin
            if (hit) begin
                if (upd_taken) begin
                    m_ctr[g][ui] = (m_ctr[g][ui] == 3) ? 3 : m_ctr[g][ui] + 1;
                    m_tgt[g][ui] = upd_target;
                end else begin
                    m_ctr[g][ui] = (m_ctr[g][ui] == 0) ? 0 : m_ctr[g][ui] - 1;
                end
            end else if (upd_taken) begin
                m_valid[g][ui] = 1'b1; m_tag[g][ui] = upd_pc >> 6; m_tgt[g][ui] = upd_target;
                m_jmp[g][ui] = 1'b0; m_ctr[g][ui] = 2;
            end
            if (g == 1) m_ghr[1] = ((m_ghr[1] << 1) | int'(upd_taken)) & 15;
        end else if (hit && upd_pred_taken) begin
            m_valid[g][ui] = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model before the edge, then advance it.
    task automatic run_cycle();
        bit ah, at, gh, gt, act, mis;
        logic [31:0] atg, gtg, cpc;
        int ai, gi;
        predict(0, if_pc, ah, at, atg, ai);
        predict(1, if_pc, gh, gt, gtg, gi);
        act = upd_is_jump || (upd_is_branch && upd_taken);
        mis = upd_valid && ((act != upd_pred_taken) || (act && (upd_pred_target != upd_target)));
        cpc = act ? upd_target : upd_pc + 32'd4;
        @(negedge clk);
        o_hit = a_pred_hit; o_tk = a_pred_taken; o_tgt = a_pred_target; o_mis = a_mispredict;
        o_cpc = a_correct_pc; o_look = a_stat_lookups; o_smis = a_stat_mispredicts;
        o_ghit = g_pred_hit; o_gidx = g_pred_index;
        chk("a_hit", 32'(a_pred_hit), 32'(ah));
        chk("a_taken", 32'(a_pred_taken), 32'(at));
        chk("a_target", a_pred_target, atg);
        chk("a_index", 32'(a_pred_index), 32'(ai));
        chk("a_mispredict", 32'(a_mispredict), 32'(mis));
        chk("a_correct_pc", a_correct_pc, cpc);
        chk("a_lookups", a_stat_lookups, m_look[0]);
        chk("a_mispredicts", a_stat_mispredicts, m_mis[0]);
        chk("g_hit", 32'(g_pred_hit), 32'(gh));
        chk("g_taken", 32'(g_pred_taken), 32'(gt));
        chk("g_target", g_pred_target, gtg);
        chk("g_index", 32'(g_pred_index), 32'(gi));
        chk("g_mispredict", 32'(g_mispredict), 32'(mis));
        chk("g_mispredicts", g_stat_mispredicts, m_mis[1]);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            model_train(0, int'(a_upd_index));
            model_train(1, int'(g_upd_index));
            for (int g = 0; g < 2; g++) begin
                if (!if_stall) m_look[g]++;
                if (mis && !upd_stall) m_mis[g]++;
            end
        end
        #1;
    endtask

    task automatic set_idle();
        upd_valid = 0; upd_stall = 0; upd_pc = 0; upd_is_branch = 0; upd_is_jump = 0;
        upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
        a_upd_index = 0; g_upd_index = 0; if_stall = 0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input bit br, input bit jmp, input bit tk,
                           input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        upd_valid = 1; upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp; upd_taken = tk;
        upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
        a_upd_index = 4'(idx_of(0, pc));
        g_upd_index = 4'(idx_of(1, pc));
    endtask

    initial begin
        bit ph, ptk;
        logic [31:0] ptg;
        int pidx;
        logic [3:0] gidx_prev;
        logic [31:0] pool [8];
        logic [31:0] saved_look, saved_mis;
        pool = '{32'h60, 32'h80, 32'hC0, 32'h100, 32'h460, 32'h1000, 32'h1004, 32'h40};

        // Reset
        rst = 1; if_pc = 32'h60; set_idle(); model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        run_cycle();
        chk("reset_hit", 32'(o_hit), 0);
        chk("reset_taken", 32'(o_tk), 0);
        chk("reset_target", o_tgt, 32'h64);
        chk("reset_lookups", o_look, 0);
        chk("reset_mispredicts", o_smis, 0);

        // Taken branch allocates
        set_upd(32'h60, 1, 0, 1, 32'h40, 0, 32'h64);
        run_cycle();
        chk("alloc_mispredict", 32'(o_mis), 1);
        chk("alloc_correct_pc", o_cpc, 32'h40);
        set_idle();
        run_cycle();
        chk("alloc_hit", 32'(o_hit), 1);
        chk("alloc_taken", 32'(o_tk), 1);
        chk("alloc_target", o_tgt, 32'h40);
        chk("alloc_stat_mis", o_smis, 1);

        // Hysteresis T,T,N,N
        for (int k = 0; k < 4; k++) begin
            predict(0, 32'h60, ph, ptk, ptg, pidx);
            set_upd(32'h60, 1, 0, (k < 2), 32'h40, ptk, ptg);
            run_cycle();
        end
        set_idle();
        run_cycle();
        chk("hyst_taken", 32'(o_tk), 0);
        chk("hyst_target", o_tgt, 32'h64);

        // jalr with wrong target, then tag aliasing
        set_upd(32'h80, 0, 1, 0, 32'h304, 1, 32'h300);
        run_cycle();
        chk("jalr_mispredict", 32'(o_mis), 1);
        chk("jalr_correct_pc", o_cpc, 32'h304);
        set_idle(); if_pc = 32'h80;
        run_cycle();
        chk("jalr_taken", 32'(o_tk), 1);
        chk("jalr_target", o_tgt, 32'h304);
        if_pc = 32'hC0;
        run_cycle();
        chk("alias_hit", 32'(o_hit), 0);

        // Stalled update resolves but does not train or count
        if_pc = 32'h100; if_stall = 1;
        set_upd(32'h100, 1, 0, 1, 32'h200, 0, 32'h104); upd_stall = 1;
        run_cycle();
        chk("stall_mispredict", 32'(o_mis), 1);
        chk("stall_correct_pc", o_cpc, 32'h200);
        saved_look = o_look; saved_mis = o_smis;
        run_cycle();
        chk("stall_no_train", 32'(o_hit), 0);
        chk("stall_lookups", o_look, saved_look);
        chk("stall_mispredicts", o_smis, saved_mis);
        upd_stall = 0;
        run_cycle();
        set_idle();
        run_cycle();
        chk("unstall_hit", 32'(o_hit), 1);
        chk("unstall_target", o_tgt, 32'h200);
        set_upd(32'h100, 1, 0, 1, 32'h200, 0, 32'h104); rst = 1;
        run_cycle();
        rst = 0; set_idle();
        run_cycle();
        chk("rst_hit", 32'(o_hit), 0);
        chk("rst_lookups", o_look, 0);
        chk("rst_mispredicts", o_smis, 0);

        // gshare learns an alternating branch
        gidx_prev = 0;
        for (int k = 0; k < 12; k++) begin
            set_idle(); if_pc = 32'h60;
            predict(1, 32'h60, ph, ptk, ptg, pidx);
            run_cycle();
            if (k >= 9) chk("gshare_index_alt", 32'(o_gidx == gidx_prev), 0);
            gidx_prev = o_gidx;
            set_upd(32'h60, 1, 0, (k % 2 == 0), 32'h40, ptk, ptg); if_pc = 32'h0;
            run_cycle();
            if (k >= 8) chk("gshare_settled", 32'(o_mis), 0);
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            set_idle();
            if_pc = pool[$urandom_range(0, 7)];
            if_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0) begin
                logic [31:0] upc;
                upc = pool[$urandom_range(0, 7)];
                r = int'($urandom_range(0, 3));
                predict(0, upc, ph, ptk, ptg, pidx);
                if ($urandom_range(0, 1) == 0) begin
                    ptk = 1'($urandom_range(0, 1));
                    ptg = pool[$urandom_range(0, 7)];
                end
                set_upd(upc, (r == 1 || r == 2), (r == 0), 1'($urandom_range(0, 1)),
                        pool[$urandom_range(0, 7)], ptk, ptg);
                upd_stall = ($urandom_range(0, 3) == 0);
            end
            rst = ($urandom_range(0, 63) == 0);
            run_cycle();
            rst = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
